add_sub_checker: RTL and testbench

Self-checking consumer for the adder/subtractor datapath. It takes each applied operand set (`select`, `a`, `b`) together with the `out`, `carry` and `zero` results the unit produced, recomputes the golden result in a two-stage pipeline, and reports pass/fail per transaction. It keeps pass and error statistics and can stall the stimulus source on the first error. It sits at the result end of the add_sub datapath, in simulation benches and optionally in on-chip self-test.

---
 rtl/add_sub_pkg.sv | 9 +
 rtl/add_sub_checker_ref.sv | 39 +++
 rtl/add_sub_checker.sv | 151 +++++++++++++++
 tb/tb_add_sub_checker.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants for the add/sub datapath and its result checker.
package add_sub_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

endpackage

// File: rtl/add_sub_checker_ref.sv
// Combinational golden model of the add/sub unit: expected out/carry/zero for one operand set.
module add_sub_ref
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_out,
  output logic             exp_carry,
  output logic             exp_zero,
  output logic             op_known
);

  logic [WIDTH:0] t;

  // For SUB the extra top bit of t is the borrow.
  always_comb begin
    t        = '0;
    op_known = 1'b0;
    case (select)
      OP_ADD: begin
        t        = {1'b0, a} + {1'b0, b};
        op_known = 1'b1;
      end
      OP_SUB: begin
        t        = {1'b0, a} - {1'b0, b};
        op_known = 1'b1;
      end
      default: ;
    endcase
  end

  assign exp_out   = t[WIDTH-1:0];
  assign exp_carry = t[WIDTH];
  assign exp_zero  = (t[WIDTH-1:0] == '0);

endmodule

// File: rtl/add_sub_checker.sv
// Two-stage self-checker for the add/sub datapath with saturating statistics and halt-on-error.
// First-failure capture registers are built only when ADD_SUB_CHK_CAPTURE_EN is defined.
module add_sub_checker
  import add_sub_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int CNT_W       = 16,
  parameter int HALT_ON_ERR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_out,
  input  logic             dut_carry,
  input  logic             dut_zero,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic             chk_skip,
  output logic             err_sticky,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [2:0]       first_err_sel,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             s1_valid;
  logic [2:0]       s1_sel;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_out;
  logic             s1_carry;
  logic             s1_zero;

  logic [WIDTH-1:0] exp_out;
  logic             exp_carry;
  logic             exp_zero;
  logic             op_known;

  logic             accept;
  logic             results_match;
  logic             checked;
  logic             mismatch;

  assign in_ready = !((HALT_ON_ERR != 0) && err_sticky);
  assign accept   = in_valid && in_ready;

  add_sub_ref #(.WIDTH(WIDTH)) u_ref (
    .select    (s1_sel),
    .a         (s1_a),
    .b         (s1_b),
    .exp_out   (exp_out),
    .exp_carry (exp_carry),
    .exp_zero  (exp_zero),
    .op_known  (op_known)
  );

  assign results_match = (s1_out == exp_out) && (s1_carry == exp_carry) && (s1_zero == exp_zero);
  assign checked       = s1_valid && op_known;
  assign mismatch      = checked && !results_match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_sel     <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_out     <= '0;
      s1_carry   <= 1'b0;
      s1_zero    <= 1'b0;
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      chk_skip   <= 1'b0;
      err_sticky <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
    end else if (clear) begin
      // A transaction offered in the clear cycle is dropped.
      s1_valid   <= 1'b0;
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      chk_skip   <= 1'b0;
      err_sticky <= 1'b0;
      chk_count  <= '0;
      err_count  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_sel   <= select;
        s1_a     <= a;
        s1_b     <= b;
        s1_out   <= dut_out;
        s1_carry <= dut_carry;
        s1_zero  <= dut_zero;
      end

      chk_valid <= s1_valid;
      chk_pass  <= s1_valid && (!op_known || results_match);
      chk_skip  <= s1_valid && !op_known;

      if (checked && (chk_count != CNT_MAX)) begin
        chk_count <= chk_count + CNT_W'(1);
      end
      if (mismatch) begin
        err_sticky <= 1'b1;
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef ADD_SUB_CHK_CAPTURE_EN
  logic [2:0]       cap_sel;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;

  // Only the first mismatch since reset/clear is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sel <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
    end else if (clear) begin
      cap_sel <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
    end else if (mismatch && !err_sticky) begin
      cap_sel <= s1_sel;
      cap_a   <= s1_a;
      cap_b   <= s1_b;
    end
  end

  assign first_err_sel = cap_sel;
  assign first_err_a   = cap_a;
  assign first_err_b   = cap_b;
`else
  assign first_err_sel = '0;
  assign first_err_a   = '0;
  assign first_err_b   = '0;
`endif

endmodule

// File: tb/tb_add_sub_checker.sv
// Directed + random bench for add_sub_checker: a halting instance checked against a transaction model,
// and a non-halting narrow-counter instance used for saturation.
module tb_add_sub_checker;

  localparam int W      = 32;
  localparam int CNT_H  = 16;
  localparam int CNT_S  = 6;
  localparam int MAX_H  = (1 << CNT_H) - 1;
  localparam int MAX_S  = (1 << CNT_S) - 1;

  logic clk = 1'b0;
  logic rst_n, clear, in_valid;
  logic [2:0]   select;
  logic [W-1:0] a, b, dut_out;
  logic         dut_carry, dut_zero;

  logic             h_ready, h_valid, h_pass, h_skip, h_sticky;
  logic [CNT_H-1:0] h_chk, h_err;
  logic [2:0]       h_cap_sel;
  logic [W-1:0]     h_cap_a, h_cap_b;

  logic             s_ready, s_valid, s_pass, s_skip, s_sticky;
  logic [CNT_S-1:0] s_chk, s_err;
  logic [2:0]       s_cap_sel;
  logic [W-1:0]     s_cap_a, s_cap_b;

  always #5 clk = ~clk;

  add_sub_checker #(.WIDTH(W), .CNT_W(CNT_H), .HALT_ON_ERR(1)) u_halt (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(h_ready),
    .select(select), .a(a), .b(b), .dut_out(dut_out), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .chk_valid(h_valid), .chk_pass(h_pass), .chk_skip(h_skip), .err_sticky(h_sticky),
    .chk_count(h_chk), .err_count(h_err),
    .first_err_sel(h_cap_sel), .first_err_a(h_cap_a), .first_err_b(h_cap_b)
  );

  add_sub_checker #(.WIDTH(W), .CNT_W(CNT_S), .HALT_ON_ERR(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(s_ready),
    .select(select), .a(a), .b(b), .dut_out(dut_out), .dut_carry(dut_carry), .dut_zero(dut_zero),
    .chk_valid(s_valid), .chk_pass(s_pass), .chk_skip(s_skip), .err_sticky(s_sticky),
    .chk_count(s_chk), .err_count(s_err),
    .first_err_sel(s_cap_sel), .first_err_a(s_cap_a), .first_err_b(s_cap_b)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // transaction-level model of the halting instance
  logic         m_s1_v;
  logic [2:0]   m_s1_sel;
  logic [W-1:0] m_s1_a, m_s1_b, m_s1_out;
  logic         m_s1_c, m_s1_z;
  logic         m_valid, m_pass, m_skip, m_sticky;
  int           m_chk, m_err;
  logic [2:0]   m_cap_sel;
  logic [W-1:0] m_cap_a, m_cap_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic void golden(input logic [2:0] sel, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic known, output logic [W-1:0] o,
                                 output logic c, output logic z);
    longint s;
    known = 1'b1;
    s     = 0;
    c     = 1'b0;
    if (sel == 3'd0) begin
      s = longint'(x) + longint'(y);
      c = (s > 64'sh0000_0000_FFFF_FFFF);
    end else if (sel == 3'd1) begin
      s = longint'(x) - longint'(y);
      c = (s < 0);
    end else begin
      known = 1'b0;
    end
    o = s[W-1:0];
    z = (o == 0);
  endfunction

  task automatic model_reset();
    m_s1_v = 0; m_s1_sel = 0; m_s1_a = 0; m_s1_b = 0; m_s1_out = 0; m_s1_c = 0; m_s1_z = 0;
    m_valid = 0; m_pass = 0; m_skip = 0; m_sticky = 0;
    m_chk = 0; m_err = 0;
    m_cap_sel = 0; m_cap_a = 0; m_cap_b = 0;
  endtask

  task automatic check_all();
    check("in_ready", h_ready, !m_sticky);
    check("chk_valid", h_valid, m_valid);
    if (m_valid) begin
      check("chk_pass", h_pass, m_pass);
      check("chk_skip", h_skip, m_skip);
    end
    check("err_sticky", h_sticky, m_sticky);
    check("chk_count", h_chk, m_chk);
    check("err_count", h_err, m_err);
`ifdef ADD_SUB_CHK_CAPTURE_EN
    check("first_err_sel", h_cap_sel, m_cap_sel);
    check("first_err_a", h_cap_a, m_cap_a);
    check("first_err_b", h_cap_b, m_cap_b);
`else
    check("first_err_sel_tied", h_cap_sel, 0);
    check("first_err_a_tied", h_cap_a, 0);
    check("first_err_b_tied", h_cap_b, 0);
`endif
  endtask

  task automatic drive_raw(input logic [2:0] sel, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] o, input logic c, input logic z);
    in_valid = 1'b1; select = sel; a = x; b = y; dut_out = o; dut_carry = c; dut_zero = z;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [W-1:0] x, input logic [W-1:0] y, input bit corrupt);
    logic k, c, z;
    logic [W-1:0] o;
    golden(sel, x, y, k, o, c, z);
    if (!k) begin
      o = $urandom; c = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
    end
    drive_raw(sel, x, y, o, c ^ corrupt, z);
  endtask

  task automatic cycle();
    logic acc, k, c, z;
    logic [W-1:0] o;
    acc = in_valid && !m_sticky;
    @(posedge clk);
    if (!rst_n || clear) begin
      model_reset();
    end else begin
      if (m_s1_v) begin
        golden(m_s1_sel, m_s1_a, m_s1_b, k, o, c, z);
        m_valid = 1;
        m_skip  = !k;
        m_pass  = !k || (o == m_s1_out && c == m_s1_c && z == m_s1_z);
        if (k) begin
          m_chk = sat(m_chk + 1, MAX_H);
          if (!m_pass) begin
            m_err = sat(m_err + 1, MAX_H);
            if (!m_sticky) begin
              m_cap_sel = m_s1_sel; m_cap_a = m_s1_a; m_cap_b = m_s1_b;
            end
            m_sticky = 1;
          end
        end
      end else begin
        m_valid = 0; m_pass = 0; m_skip = 0;
      end
      m_s1_v = acc;
      if (acc) begin
        m_s1_sel = select; m_s1_a = a; m_s1_b = b; m_s1_out = dut_out; m_s1_c = dut_carry; m_s1_z = dut_zero;
      end
    end
    #1;
    check_all();
  endtask

  function automatic logic [2:0] rand_sel();
    int r;
    r = $urandom_range(0, 3);
    return (r < 2) ? 3'(r) : 3'($urandom_range(2, 7));
  endfunction

  function automatic logic [W-1:0] rand_opnd();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 0; clear = 0; in_valid = 0; select = 0; a = 0; b = 0;
    dut_out = 0; dut_carry = 0; dut_zero = 0;
    model_reset();
    #12;
    check_all();
    check("rst_chk_pass", h_pass, 0);
    check("rst_chk_skip", h_skip, 0);
    check("rst_sat_ready", s_ready, 1);
    rst_n = 1;
    cycle();

    // ADD wrap to zero with carry out
    drive_raw(3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b1);
    cycle();
    in_valid = 0;
    cycle();
    check("t1_pass", h_pass, 1);
    check("t1_chk_count", h_chk, 1);
    check("t1_err_count", h_err, 0);

    // SUB with borrow, correct then wrong carry
    drive_raw(3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
    cycle();
    drive_raw(3'b001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    cycle();
    check("t2_pass_ok", h_pass, 1);
    in_valid = 0;
    cycle();
    check("t2_fail", h_pass, 0);
    check("t2_sticky", h_sticky, 1);
`ifdef ADD_SUB_CHK_CAPTURE_EN
    check("t2_first_err_a", h_cap_a, 5);
`endif
    cycle();
    clear = 1;
    cycle();
    clear = 0;

    // unchecked opcode
    drive(3'b101, $urandom, $urandom, 0);
    cycle();
    in_valid = 0;
    cycle();
    check("t3_skip", h_skip, 1);
    check("t3_pass", h_pass, 1);
    check("t3_chk_count", h_chk, 0);
    cycle();

    // halt: 2nd fails, 3rd still checked, 4th waits for clear
    drive(3'b000, $urandom, $urandom, 0);
    cycle();
    drive(3'b001, $urandom, $urandom, 1);
    cycle();
    drive(3'b000, $urandom, $urandom, 0);
    cycle();
    drive(3'b001, 32'd100, 32'd100, 0);
    repeat (4) cycle();
    check("t4_ready_low", h_ready, 0);
    check("t4_chk_count", h_chk, 3);
    check("t4_err_count", h_err, 1);
    clear = 1;
    cycle();
    clear = 0;
    cycle();
    in_valid = 0;
    cycle();
    check("t4_held_checked", h_valid, 1);
    check("t4_held_zero_pass", h_pass, 1);

    // random clean stream, then a stream with occasional faults
    for (int i = 0; i < 60; i++) begin
      drive(rand_sel(), rand_opnd(), rand_opnd(), 0);
      cycle();
    end
    in_valid = 0;
    repeat (2) cycle();
    for (int i = 0; i < 12; i++) begin
      drive(3'($urandom_range(0, 1)), rand_opnd(), rand_opnd(), ($urandom_range(0, 3) == 0));
      cycle();
    end
    in_valid = 0;
    repeat (2) cycle();

    // clear wins over a same-cycle transaction
    drive(3'b000, $urandom, $urandom, 0);
    clear = 1;
    cycle();
    clear = 0;
    in_valid = 0;
    repeat (2) cycle();
    check("t6_clear_drop_valid", h_valid, 0);
    check("t6_clear_drop_count", h_chk, 0);

    // saturation on the non-halting narrow-counter instance
    drive(3'b000, $urandom, $urandom, 1);
    clear = 1;
    cycle();
    clear = 0;
    for (int i = 1; i <= MAX_S + 8; i++) begin
      drive(3'b000, $urandom, $urandom, 1);
      cycle();
      check("t5_sat_err", s_err, sat(i - 1, MAX_S));
      check("t5_sat_ready", s_ready, 1);
    end
    in_valid = 0;
    repeat (2) cycle();
    check("t5_sat_err_final", s_err, MAX_S);
    check("t5_sat_chk_final", s_chk, MAX_S);
    check("t5_sat_sticky", s_sticky, 1);
    clear = 1;
    cycle();
    clear = 0;

    // async reset with both stages full
    drive(3'b000, $urandom, $urandom, 0);
    cycle();
    drive(3'b001, $urandom, $urandom, 0);
    cycle();
    in_valid = 0;
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check_all();
    check("t6_rst_pass", h_pass, 0);
    check("t6_rst_skip", h_skip, 0);
    check("t6_rst_sat_valid", s_valid, 0);
    check("t6_rst_sat_chk", s_chk, 0);
    cycle();
    #2;
    rst_n = 1;
    repeat (3) cycle();
    check("t6_no_pulse", h_valid, 0);
    check("t6_sat_no_pulse", s_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
